// File: rtl/lot_pkg.sv
// Shared types and constants for the parking-lot occupancy controller.
package lot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    LOCKED = 2'd2
  } gate_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Extracts one decimal digit of an elaboration-time integer, e.g. place=10 gives the tens digit.
  function automatic bcd_t bcd_digit(input int value, input int place);
    return bcd_t'((value / place) % 10);
  endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// One BCD digit that counts up or down, flagging carry out of 9 and borrow out of 0.
module bcd_updown_digit
  import lot_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic up,
  input  logic down,
  output bcd_t digit,
  output bcd_t digit_next,
  output logic carry,
  output logic borrow
);

  bcd_t digit_q;
  bcd_t digit_d;

  // Next digit value: 9 wraps to 0 with carry on up, 0 wraps to 9 with borrow on down; up and down together cancel.
  always_comb begin
    digit_d = digit_q;
    carry   = 1'b0;
    borrow  = 1'b0;
    if (up && !down) begin
      if (digit_q == BCD_MAX) begin
        digit_d = '0;
        carry   = 1'b1;
      end else begin
        digit_d = digit_q + 4'd1;
      end
    end else if (down && !up) begin
      if (digit_q == '0) begin
        digit_d = BCD_MAX;
        borrow  = 1'b1;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end
  end

  // Digit register with synchronous active-low reset to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign digit_next = digit_d;

endmodule

// File: rtl/lot_controller.sv
// Parking-lot occupancy controller: saturating two-digit BCD count, entry/exit
// arbitration, timed entry gate FSM and registered status outputs.
module lot_controller
  import lot_pkg::*;
#(
  parameter int CAPACITY    = 99,
  parameter int GATE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       full,
  output logic       empty,
  output logic       gate_open,
  output logic       reject,
  output logic       underflow
);

  localparam bcd_t CAP_TENS = bcd_digit(CAPACITY, 10);
  localparam bcd_t CAP_ONES = bcd_digit(CAPACITY, 1);

  localparam int TIMER_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(GATE_CYCLES - 1);

  logic inc_accept;
  logic dec_accept;
  logic both_events;

  bcd_t ones_digit;
  bcd_t ones_next;
  bcd_t tens_digit;
  bcd_t tens_next;
  logic ones_carry;
  logic ones_borrow;
  logic tens_carry;
  logic tens_borrow;

  logic full_q;
  logic full_d;
  logic empty_q;
  logic empty_d;
  logic reject_q;
  logic reject_d;
  logic underflow_q;
  logic underflow_d;

  gate_state_t state_q;
  gate_state_t state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic gate_open_q;
  logic gate_open_d;

  // Arbitrate the event strobes against the registered full/empty flags so the count saturates at both ends.
  always_comb begin
    both_events = inc && dec;
    inc_accept  = inc && !dec && !full_q;
    dec_accept  = dec && !inc && !empty_q;
    reject_d    = inc && !dec && full_q;
    underflow_d = dec && !inc && empty_q;
  end

  bcd_updown_digit u_ones (
    .clk        (clk),
    .reset      (reset),
    .up         (inc_accept),
    .down       (dec_accept),
    .digit      (ones_digit),
    .digit_next (ones_next),
    .carry      (ones_carry),
    .borrow     (ones_borrow)
  );

  bcd_updown_digit u_tens (
    .clk        (clk),
    .reset      (reset),
    .up         (ones_carry),
    .down       (ones_borrow),
    .digit      (tens_digit),
    .digit_next (tens_next),
    .carry      (tens_carry),
    .borrow     (tens_borrow)
  );

  // Status flags are derived from the next count so they line up with the registered digits.
  always_comb begin
    full_d  = (tens_next == CAP_TENS) && (ones_next == CAP_ONES);
    empty_d = (tens_next == '0) && (ones_next == '0);
  end

  // Gate FSM next state: entries open the gate and restart the hold timer, filling the lot locks it shut.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (inc_accept) begin
          if (full_d) begin
            state_d = LOCKED;
            timer_d = '0;
          end else begin
            state_d = OPEN;
            timer_d = TIMER_RELOAD;
          end
        end
      end
      OPEN: begin
        if (full_d) begin
          state_d = LOCKED;
          timer_d = '0;
        end else if (inc_accept || both_events) begin
          timer_d = TIMER_RELOAD;
        end else if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      LOCKED: begin
        timer_d = '0;
        if (dec_accept) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    gate_open_d = (state_d == OPEN);
  end

  // Register FSM, timer and every status output; reset overrides any same-cycle event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      gate_open_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      reject_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gate_open_q <= gate_open_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      reject_q    <= reject_d;
      underflow_q <= underflow_d;
    end
  end

  // The tens digit can never roll over because the count saturates at CAPACITY and at zero.
  tens_never_wraps: assert property (@(posedge clk) disable iff (!reset) !(tens_carry || tens_borrow));

  assign tens      = tens_digit;
  assign ones      = ones_digit;
  assign full      = full_q;
  assign empty     = empty_q;
  assign gate_open = gate_open_q;
  assign reject    = reject_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_lot_controller.sv
// Self-checking bench for lot_controller: two instances (large and small lot)
// share one stimulus stream and are compared every cycle against a counting model.
module tb_lot_controller;
  import lot_pkg::*;

  localparam int GATE = 16;
  localparam int CAP_BIG = 99;
  localparam int CAP_SMALL = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic inc = 1'b0;
  logic dec = 1'b0;

  logic [3:0] tens_b, ones_b, tens_s, ones_s;
  logic full_b, empty_b, gate_b, reject_b, underflow_b;
  logic full_s, empty_s, gate_s, reject_s, underflow_s;

  logic [12:0] obs [2];

  int passed = 0;
  int total = 0;

  int  cap [2] = '{CAP_BIG, CAP_SMALL};
  int  m_count [2];
  int  m_rem [2];
  bit  m_locked [2];
  bit  m_rej [2];
  bit  m_und [2];

  always #5 clk = ~clk;

  lot_controller #(.CAPACITY(CAP_BIG), .GATE_CYCLES(GATE)) dut_big (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec),
    .tens(tens_b), .ones(ones_b), .full(full_b), .empty(empty_b),
    .gate_open(gate_b), .reject(reject_b), .underflow(underflow_b)
  );

  lot_controller #(.CAPACITY(CAP_SMALL), .GATE_CYCLES(GATE)) dut_small (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec),
    .tens(tens_s), .ones(ones_s), .full(full_s), .empty(empty_s),
    .gate_open(gate_s), .reject(reject_s), .underflow(underflow_s)
  );

  assign obs[0] = {tens_b, ones_b, full_b, empty_b, gate_b, reject_b, underflow_b};
  assign obs[1] = {tens_s, ones_s, full_s, empty_s, gate_s, reject_s, underflow_s};

  // Reference: occupancy as an integer, gate as "cycles of open time remaining".
  task automatic model_update(input int k, input logic r, input logic i, input logic d);
    bit was_full;
    bit was_empty;
    if (!r) begin
      m_count[k] = 0; m_rem[k] = 0; m_locked[k] = 0; m_rej[k] = 0; m_und[k] = 0;
      return;
    end
    m_rej[k] = 0;
    m_und[k] = 0;
    was_full  = (m_count[k] == cap[k]);
    was_empty = (m_count[k] == 0);
    if (i && d) begin
      if (m_rem[k] > 0) m_rem[k] = GATE;
    end else if (i) begin
      if (was_full) begin
        m_rej[k] = 1;
        if (m_rem[k] > 0) m_rem[k]--;
      end else begin
        m_count[k]++;
        if (m_count[k] == cap[k]) begin
          m_locked[k] = 1;
          m_rem[k] = 0;
        end else begin
          m_rem[k] = GATE;
        end
      end
    end else begin
      if (d) begin
        if (was_empty) m_und[k] = 1;
        else begin
          m_count[k]--;
          m_locked[k] = 0;
        end
      end
      if (m_rem[k] > 0) m_rem[k]--;
    end
  endtask

  function automatic logic [12:0] exp_vec(input int k);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(m_count[k] / 10);
    o = 4'(m_count[k] % 10);
    return {t, o, m_count[k] == cap[k], m_count[k] == 0, m_rem[k] > 0, m_rej[k], m_und[k]};
  endfunction

  function automatic gate_state_t exp_state(input int k);
    if (m_locked[k]) return LOCKED;
    if (m_rem[k] > 0) return OPEN;
    return IDLE;
  endfunction

  // Drive one cycle of stimulus away from the edge, advance the model, sample after the edge.
  task automatic applyStimulus(input logic r, input logic i, input logic d);
    @(negedge clk);
    reset = r; inc = i; dec = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k, r, i, d);
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 4; n++) begin
      applyStimulus(n == 3, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k))
          $display("[TB] FAIL reset[%0d] step %0d: got %h want %h", k, n, obs[k], exp_vec(k));
        else passed++;
      end
    end
  endtask

  task automatic test_count_up();
    for (int n = 0; n < 12 + GATE + 2; n++) begin
      applyStimulus(1'b1, n < 12, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k))
          $display("[TB] FAIL count_up[%0d] step %0d: got %h want %h", k, n, obs[k], exp_vec(k));
        else passed++;
      end
    end
    total++;
    if ({tens_b, ones_b} !== 8'h12)
      $display("[TB] FAIL count_up_final: got %h want 12", {tens_b, ones_b});
    else passed++;
  endtask

  task automatic test_full_lock();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 7; n++) begin
      applyStimulus(1'b1, n < 6, n == 6);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k))
          $display("[TB] FAIL full_lock[%0d] step %0d: got %h want %h", k, n, obs[k], exp_vec(k));
        else passed++;
      end
      total++;
      if (dut_small.state_q !== exp_state(1))
        $display("[TB] FAIL full_lock_state step %0d: got %0d want %0d", n, dut_small.state_q, exp_state(1));
      else passed++;
    end
  endtask

  task automatic test_borrow_underflow();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 23; n++) begin
      applyStimulus(1'b1, n < 10, n >= 10);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k))
          $display("[TB] FAIL borrow[%0d] step %0d: got %h want %h", k, n, obs[k], exp_vec(k));
        else passed++;
      end
    end
  endtask

  task automatic test_simultaneous();
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 7; n++) applyStimulus(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 5; n++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < GATE + 2; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k))
          $display("[TB] FAIL simul_reload[%0d] step %0d: got %h want %h", k, n, obs[k], exp_vec(k));
        else passed++;
      end
    end
    for (int n = 0; n < CAP_BIG - 7; n++) applyStimulus(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k))
          $display("[TB] FAIL simul_cap[%0d] step %0d: got %h want %h", k, n, obs[k], exp_vec(k));
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 37; n++) applyStimulus(1'b1, 1'b1, 1'b0);
    total++;
    if (dut_big.state_q !== OPEN || {tens_b, ones_b} !== 8'h37)
      $display("[TB] FAIL reset_mid_pre: got state %0d count %h want state %0d count 37",
               dut_big.state_q, {tens_b, ones_b}, OPEN);
    else passed++;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== exp_vec(k))
        $display("[TB] FAIL reset_mid[%0d]: got %h want %h", k, obs[k], exp_vec(k));
      else passed++;
    end
    total++;
    if (dut_big.state_q !== exp_state(0))
      $display("[TB] FAIL reset_mid_state: got %0d want %0d", dut_big.state_q, exp_state(0));
    else passed++;
  endtask

  task automatic test_random();
    logic r;
    logic i;
    logic d;
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 1500; n++) begin
      r = ($urandom_range(0, 199) != 0);
      i = ($urandom_range(0, 99) < 45);
      d = ($urandom_range(0, 99) < 30);
      if (n % 300 >= 250) begin
        i = 1'b0;
        d = ($urandom_range(0, 9) == 0);
      end
      applyStimulus(r, i, d);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k))
          $display("[TB] FAIL random[%0d] step %0d: got %h want %h", k, n, obs[k], exp_vec(k));
        else passed++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_count_up();
    test_full_lock();
    test_borrow_underflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
